// File: rtl/uart_transmitter_fifo_param.sv
// Buffered serial transmitter: a power-of-two TX FIFO feeding a framing FSM
// with run-time parity, stop-bit and baud-divisor selection latched per frame.
module uart_transmitter_fifo_param #(
    parameter int DATA_WIDTH = 8,
    parameter int FIFO_DEPTH = 64,
    parameter int BAUD_DIV_0 = 868,
    parameter int BAUD_DIV_1 = 434,
    parameter int BAUD_DIV_2 = 217,
    parameter int BAUD_DIV_3 = 109
) (
    input  logic                          clock,
    input  logic                          reset,
    input  logic [DATA_WIDTH-1:0]         data_in,
    input  logic                          write_enable,
    input  logic [$clog2(FIFO_DEPTH)-1:0] buffer_full_threshold,
    input  logic [1:0]                    baudrate_select,
    input  logic [1:0]                    parity_mode,
    input  logic                          stop_bits,
    input  logic                          overflow_clear,
    output logic                          buffer_full,
    output logic                          buffer_empty,
    output logic [$clog2(FIFO_DEPTH):0]   buffer_count,
    output logic                          overflow,
    output logic                          busy,
    output logic                          data_out
);

    localparam int AW      = $clog2(FIFO_DEPTH);
    localparam int IW      = $clog2(DATA_WIDTH);
    localparam int MAX_01  = (BAUD_DIV_0 > BAUD_DIV_1) ? BAUD_DIV_0 : BAUD_DIV_1;
    localparam int MAX_23  = (BAUD_DIV_2 > BAUD_DIV_3) ? BAUD_DIV_2 : BAUD_DIV_3;
    localparam int MAX_DIV = (MAX_01 > MAX_23) ? MAX_01 : MAX_23;
    localparam int BW      = $clog2(MAX_DIV);

    localparam logic [AW:0]   DEPTH_C  = (AW+1)'(FIFO_DEPTH);
    localparam logic [IW-1:0] LAST_BIT = IW'(DATA_WIDTH - 1);

    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

    // The bit-period counter runs from DIV-1 down to 0, so it holds DIV-1.
    function automatic logic [BW-1:0] reload_value(input logic [1:0] sel);
        case (sel)
            2'd0:    return BW'(BAUD_DIV_0 - 1);
            2'd1:    return BW'(BAUD_DIV_1 - 1);
            2'd2:    return BW'(BAUD_DIV_2 - 1);
            default: return BW'(BAUD_DIV_3 - 1);
        endcase
    endfunction

    logic [DATA_WIDTH-1:0] mem [FIFO_DEPTH];
    logic [AW-1:0]         wr_ptr;
    logic [AW-1:0]         rd_ptr;
    logic [AW:0]           count;
    logic [AW:0]           count_next;
    logic                  do_write;
    logic                  do_pop;
    logic                  frame_end;
    logic [DATA_WIDTH-1:0] head;

    state_t                state;
    logic [BW-1:0]         baud_cnt;
    logic                  bit_tick;
    logic [IW-1:0]         bit_idx;
    logic                  stop_idx;
    logic [DATA_WIDTH-1:0] shift;
    logic [1:0]            baud_sel_l;
    logic                  par_en;
    logic                  par_bit;
    logic                  two_stop;

    assign head      = mem[rd_ptr];
    assign bit_tick  = (baud_cnt == '0);
    assign frame_end = (state == STOP) && bit_tick && (!two_stop || stop_idx);
    // A new frame starts from IDLE or straight out of the last stop bit.
    assign do_pop    = (count != '0) && ((state == IDLE) || frame_end);
    assign do_write  = write_enable && (count != DEPTH_C);

    always_comb begin
        count_next = count;
        case ({do_write, do_pop})
            2'b10:   count_next = count + 1'b1;
            2'b01:   count_next = count - 1'b1;
            default: count_next = count;
        endcase
    end

    assign buffer_count = count;
    assign buffer_full  = (count >= {1'b0, buffer_full_threshold}) || (count == DEPTH_C);

    always_ff @(posedge clock) begin
        if (do_write) begin
            mem[wr_ptr] <= data_in;
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            wr_ptr       <= '0;
            rd_ptr       <= '0;
            count        <= '0;
            buffer_empty <= 1'b1;
            overflow     <= 1'b0;
        end else begin
            if (do_write) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            count        <= count_next;
            buffer_empty <= (count_next == '0);
            // A dropped write outranks a simultaneous clear.
            if (write_enable && (count == DEPTH_C)) begin
                overflow <= 1'b1;
            end else if (overflow_clear) begin
                overflow <= 1'b0;
            end
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state      <= IDLE;
            data_out   <= 1'b1;
            busy       <= 1'b0;
            baud_cnt   <= '0;
            bit_idx    <= '0;
            stop_idx   <= 1'b0;
            shift      <= '0;
            baud_sel_l <= 2'd0;
            par_en     <= 1'b0;
            par_bit    <= 1'b0;
            two_stop   <= 1'b0;
        end else if (do_pop) begin
            state      <= START;
            data_out   <= 1'b0;
            busy       <= 1'b1;
            baud_cnt   <= reload_value(baudrate_select);
            shift      <= head;
            baud_sel_l <= baudrate_select;
            par_en     <= parity_mode[0] ^ parity_mode[1];
            par_bit    <= (^head) ^ parity_mode[1];
            two_stop   <= stop_bits;
        end else if (state != IDLE) begin
            if (!bit_tick) begin
                baud_cnt <= baud_cnt - 1'b1;
            end else begin
                baud_cnt <= reload_value(baud_sel_l);
                case (state)
                    START: begin
                        state    <= DATA;
                        data_out <= shift[0];
                        shift    <= shift >> 1;
                        bit_idx  <= '0;
                    end
                    DATA: begin
                        if (bit_idx == LAST_BIT) begin
                            if (par_en) begin
                                state    <= PARITY;
                                data_out <= par_bit;
                            end else begin
                                state    <= STOP;
                                data_out <= 1'b1;
                                stop_idx <= 1'b0;
                            end
                        end else begin
                            data_out <= shift[0];
                            shift    <= shift >> 1;
                            bit_idx  <= bit_idx + 1'b1;
                        end
                    end
                    PARITY: begin
                        state    <= STOP;
                        data_out <= 1'b1;
                        stop_idx <= 1'b0;
                    end
                    STOP: begin
                        if (!frame_end) begin
                            stop_idx <= 1'b1;
                        end else begin
                            state <= IDLE;
                            busy  <= 1'b0;
                        end
                    end
                    default: begin
                        state    <= IDLE;
                        data_out <= 1'b1;
                        busy     <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule
